core_wb_arbiter: RTL and testbench

//  Consumer end of the execution-unit writeback interface: collects wb_line results from N units
//  (ALU, shifter/mul, load unit), buffers them in per-unit FIFOs and arbitrates them onto the

---
 rtl/core_wb_arbiter_pkg.sv | 28 ++
 rtl/core_wb_fifo.sv | 62 ++++++
 rtl/core_wb_arbiter.sv | 120 ++++++++++++
 tb/tb_core_wb_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: result lines, FIFO entries and
// register-file widths used by both the arbiter and its per-unit FIFOs.
package core_wb_arbiter_pkg;

    localparam int W     = 16;
    localparam int NREGS = 16;
    localparam int RW    = $clog2(NREGS);

    typedef logic [W-1:0]     word_t;
    typedef logic [NREGS-1:0] hword_t;
    typedef logic [RW-1:0]    reg_num_t;

    typedef struct packed {
        reg_num_t rd;
        word_t    value;
        logic     ready;
    } wb_line_t;

    typedef struct packed {
        reg_num_t rd;
        word_t    value;
    } wb_entry_t;

    function automatic hword_t reg_onehot(input reg_num_t rd);
        return hword_t'(1) << rd;
    endfunction

endpackage

// File: rtl/core_wb_fifo.sv
// Single-push / single-pop synchronous FIFO holding writeback entries for one
// execution unit. A full FIFO accepts a push only when it pops in the same cycle.
module core_wb_fifo
    import core_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  wb_entry_t              i_data,
    input  logic                   i_pop,
    output wb_entry_t              o_head,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

    // NOTE: storage has no reset; r_count alone decides which entries are valid,
    // so the array can map onto plain RAM/flops without a reset network.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && w_full && !i_pop));

endmodule

// File: rtl/core_wb_arbiter.sv
// Writeback collector: buffers per-unit results, round-robin arbitrates them onto
// the single register-file write port and maintains the RAW pending scoreboard.
module core_wb_arbiter
    import core_wb_arbiter_pkg::*;
#(
    parameter int UNITS = 3,
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  wb_line_t i_wb       [UNITS],
    input  hword_t   i_raw_mask [UNITS],
    output logic     o_rf_we,
    output reg_num_t o_rf_rd,
    output word_t    o_rf_value,
    output hword_t   o_pending,
    output logic     o_stall
);

    localparam int RRW = $clog2(UNITS);
    localparam int CW  = $clog2(DEPTH) + 1;

    wb_entry_t      w_push_data [UNITS];
    wb_entry_t      w_head      [UNITS];
    logic [CW-1:0]  w_count     [UNITS];
    logic [UNITS-1:0] w_empty;
    logic [UNITS-1:0] w_pop;

    logic [RRW-1:0] r_rr;
    logic [RRW-1:0] w_grant;
    logic [RRW-1:0] w_rr_next;
    logic           w_grant_valid;
    wb_entry_t      w_win;

    logic     r_rf_we;
    reg_num_t r_rf_rd;
    word_t    r_rf_value;
    hword_t   r_pending;
    hword_t   w_set;
    hword_t   w_clr;
    logic     w_stall;

    for (genvar u = 0; u < UNITS; u++) begin : g_fifo
        assign w_push_data[u] = '{rd: i_wb[u].rd, value: i_wb[u].value};
        assign w_pop[u]       = w_grant_valid && (w_grant == RRW'(u));

        core_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (i_wb[u].ready),
            .i_data  (w_push_data[u]),
            .i_pop   (w_pop[u]),
            .o_head  (w_head[u]),
            .o_empty (w_empty[u]),
            .o_count (w_count[u])
        );
    end

    // NOTE: every signal driven here gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        int idx;
        w_grant_valid = 1'b0;
        w_grant       = r_rr;
        idx           = 0;
        for (int k = 0; k < UNITS; k++) begin
            idx = int'(r_rr) + k;
            if (idx >= UNITS) idx = idx - UNITS;
            if (!w_grant_valid && !w_empty[idx]) begin
                w_grant_valid = 1'b1;
                w_grant       = RRW'(idx);
            end
        end
    end

    assign w_win     = w_head[w_grant];
    assign w_rr_next = (w_grant == RRW'(UNITS - 1)) ? '0 : w_grant + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we    <= 1'b0;
            r_rf_rd    <= '0;
            r_rf_value <= '0;
            r_rr       <= '0;
        end else begin
            r_rf_we <= w_grant_valid;
            if (w_grant_valid) begin
                r_rf_rd    <= w_win.rd;
                r_rf_value <= w_win.value;
                r_rr       <= w_rr_next;
            end
        end
    end

    // Set is applied after clear so a register re-issued in its retire cycle stays pending.
    always_comb begin
        w_set = '0;
        for (int u = 0; u < UNITS; u++) w_set = w_set | i_raw_mask[u];
        w_clr = w_grant_valid ? reg_onehot(w_win.rd) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pending <= '0;
        else        r_pending <= (r_pending & ~w_clr) | w_set;
    end

    always_comb begin
        w_stall = 1'b0;
        for (int u = 0; u < UNITS; u++) begin
            if (w_count[u] >= CW'(DEPTH - 1)) w_stall = 1'b1;
        end
    end

    assign o_rf_we    = r_rf_we;
    assign o_rf_rd    = r_rf_rd;
    assign o_rf_value = r_rf_value;
    assign o_pending  = r_pending;
    assign o_stall    = w_stall;

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Self-checking bench for core_wb_arbiter: directed scenarios plus random traffic
// compared each cycle against a queue-based behavioural model.
module tb_core_wb_arbiter;
    import core_wb_arbiter_pkg::*;

    localparam int UNITS = 3;
    localparam int DEPTH = 4;

    logic     clk = 1'b0;
    logic     rst_n;
    wb_line_t wb       [UNITS];
    hword_t   raw_mask [UNITS];
    logic     rf_we;
    reg_num_t rf_rd;
    word_t    rf_value;
    hword_t   pending;
    logic     stall;

    always #5 clk = ~clk;

    core_wb_arbiter #(.UNITS(UNITS), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wb       (wb),
        .i_raw_mask (raw_mask),
        .o_rf_we    (rf_we),
        .o_rf_rd    (rf_rd),
        .o_rf_value (rf_value),
        .o_pending  (pending),
        .o_stall    (stall)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: one queue per unit, rotating priority, scoreboard word.
    wb_entry_t m_q [UNITS][$];
    int        m_rr;
    logic      m_we;
    int        m_rd;
    int        m_value;
    hword_t    m_pend;

    task automatic model_reset();
        for (int u = 0; u < UNITS; u++) m_q[u].delete();
        m_rr = 0; m_we = 1'b0; m_rd = 0; m_value = 0; m_pend = '0;
    endtask

    function automatic logic model_stall();
        for (int u = 0; u < UNITS; u++)
            if (m_q[u].size() >= DEPTH - 1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle_inputs();
        for (int u = 0; u < UNITS; u++) begin
            wb[u]       = '0;
            raw_mask[u] = '0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".we"},      32'(rf_we),    32'(m_we));
        check({tag, ".rd"},      32'(rf_rd),    32'(m_rd));
        check({tag, ".value"},   32'(rf_value), 32'(m_value));
        check({tag, ".pending"}, 32'(pending),  32'(m_pend));
        check({tag, ".stall"},   32'(stall),    32'(model_stall()));
    endtask

    // Apply the currently driven inputs for one clock, advance the model, check.
    task automatic cycle(input string tag);
        int        w;
        hword_t    clr;
        hword_t    set;
        wb_entry_t e;
        w = -1;
        for (int k = 0; k < UNITS; k++) begin
            int idx;
            idx = (m_rr + k) % UNITS;
            if (w < 0 && m_q[idx].size() > 0) w = idx;
        end
        clr = '0;
        if (w >= 0) begin
            e       = m_q[w].pop_front();
            m_we    = 1'b1;
            m_rd    = int'(e.rd);
            m_value = int'(e.value);
            m_rr    = (w + 1) % UNITS;
            clr     = hword_t'(1) << e.rd;
        end else begin
            m_we = 1'b0;
        end
        set = '0;
        for (int u = 0; u < UNITS; u++) set = set | raw_mask[u];
        m_pend = (m_pend & ~clr) | set;
        for (int u = 0; u < UNITS; u++) begin
            if (wb[u].ready) begin
                if (m_q[u].size() >= DEPTH) wb[u].ready = 1'b0;
                else m_q[u].push_back('{rd: wb[u].rd, value: wb[u].value});
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
        idle_inputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("reset.we",      32'(rf_we),   32'd0);
        check("reset.pending", 32'(pending), 32'd0);
        check("reset.stall",   32'(stall),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (m_q[0].size() + m_q[1].size() + m_q[2].size() == 0 && !m_we) break;
            cycle(tag);
        end
        check({tag, ".drained"}, 32'(m_q[0].size() + m_q[1].size() + m_q[2].size()), 32'd0);
    endtask

    initial begin
        logic saw_stall;
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #2;
        check_all("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Single result: visible on the write port two edges after ready.
        wb[0] = '{rd: 4'd3, value: 16'h00A5, ready: 1'b1};
        cycle("single.c0");
        cycle("single.c1");
        check("single.we",    32'(rf_we),    32'd1);
        check("single.rd",    32'(rf_rd),    32'd3);
        check("single.value", 32'(rf_value), 32'h00A5);
        cycle("single.c2");
        check("single.we_low", 32'(rf_we), 32'd0);

        // Contention from rr=0, then an immediate second round.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int u = 0; u < UNITS; u++)
                wb[u] = '{rd: reg_num_t'(u + 1 + 4 * r), value: word_t'(16'h1000 * (r + 1) + u), ready: 1'b1};
            cycle("contend.push");
        end
        check("contend.first_rd", 32'(rf_rd), 32'd1);
        drain("contend");

        // Scoreboard: set at issue, cleared at write, set wins on collision.
        raw_mask[0] = 16'h0020;
        cycle("sb.issue");
        check("sb.set", 32'(pending[5]), 32'd1);
        cycle("sb.wait");
        wb[0] = '{rd: 4'd5, value: 16'h5555, ready: 1'b1};
        cycle("sb.result");
        raw_mask[0] = 16'h0020;
        cycle("sb.write_and_reissue");
        check("sb.set_wins", 32'(pending[5]), 32'd1);
        wb[0] = '{rd: 4'd5, value: 16'h5556, ready: 1'b1};
        cycle("sb.result2");
        cycle("sb.write2");
        check("sb.cleared", 32'(pending[5]), 32'd0);

        // Back-pressure: two units flood, issue honours stall.
        saw_stall = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (!model_stall()) begin
                wb[0] = '{rd: reg_num_t'(i), value: word_t'(16'h0100 + i), ready: 1'b1};
                wb[1] = '{rd: reg_num_t'(i), value: word_t'(16'h0200 + i), ready: 1'b1};
            end
            cycle("flood");
            saw_stall = saw_stall | stall;
        end
        check("flood.stall_seen", 32'(saw_stall), 32'd1);
        drain("flood");

        // Wrap: 3*DEPTH values through one FIFO.
        for (int i = 0; i < 3 * DEPTH; i++) begin
            wb[2] = '{rd: reg_num_t'(i), value: word_t'(i), ready: 1'b1};
            cycle("wrap");
        end
        drain("wrap");

        // Asynchronous reset while results are buffered.
        for (int i = 0; i < 3; i++) begin
            for (int u = 0; u < UNITS; u++) begin
                wb[u]       = '{rd: reg_num_t'(u + 1), value: word_t'(16'hA000 + 16 * i + u), ready: 1'b1};
                raw_mask[u] = hword_t'(1) << (u + 1);
            end
            cycle("rstmid.fill");
        end
        check("rstmid.pending_before", 32'(pending), 32'h000E);
        check("rstmid.stall_before",   32'(stall),   32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rstmid.async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle("rstmid.quiet");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            for (int u = 0; u < UNITS; u++) begin
                wb[u] = '{rd: reg_num_t'($urandom_range(0, NREGS - 1)),
                          value: word_t'($urandom),
                          ready: ($urandom_range(0, 2) == 0)};
                raw_mask[u] = ($urandom_range(0, 3) == 0) ? (hword_t'(1) << $urandom_range(0, NREGS - 1)) : '0;
            end
            cycle("random");
        end
        drain("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
